strela_ctrl_csr: RTL and testbench

Parametrised control/status register file for the STRELA CGRA, driven by the register-bus slave interface. It holds per-channel input and output DMA descriptors for N_IN / N_OUT nodes and the configuration descriptor. It sequences configuration load and execution through a small FSM, with sticky done flags, an illegal-command flag and an execution cycle counter. It sits between the host register bus and the CGRA memory nodes and bitstream loader.

---
 rtl/strela_ctrl_csr_pkg.sv | 64 ++++++
 rtl/strela_ctrl_csr_if.sv | 10 +
 rtl/strela_ctrl_csr_seq.sv | 90 +++++++++
 rtl/strela_ctrl_csr.sv | 154 +++++++++++++++
 tb/tb_strela_ctrl_csr.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/strela_ctrl_csr_pkg.sv
// Shared types, register map offsets, field indices and reset values for the
// STRELA CGRA control/status register file.
package strela_csr_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    localparam int unsigned CSR_CTRL     = 32'h00;
    localparam int unsigned CSR_STATUS   = 32'h04;
    localparam int unsigned CSR_CYCLES   = 32'h08;
    localparam int unsigned CSR_IRQ_EN   = 32'h0C;
    localparam int unsigned CSR_CFG_ADDR = 32'h10;
    localparam int unsigned CSR_CFG_SIZE = 32'h14;
    localparam int unsigned CH_BASE      = 32'h20;
    localparam int unsigned CH_STRIDE    = 8;

    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_LOAD     = 1;
    localparam int unsigned CTRL_RESET_SM = 2;
    localparam int unsigned CTRL_CLEAR    = 3;

    localparam int unsigned ST_DONE_EXEC = 0;
    localparam int unsigned ST_DONE_CFG  = 1;
    localparam int unsigned ST_BUSY_EXEC = 2;
    localparam int unsigned ST_BUSY_CFG  = 3;
    localparam int unsigned ST_CMD_ERR   = 4;

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        EXEC
    } ctrl_state_e;

    localparam logic [31:0] IN_ADDR_RST   = 32'h8000_0000;
    localparam logic [31:0] IN_ADDR_STEP  = 32'h0100_0004;
    localparam logic [15:0] IN_STRIDE_RST = 16'h0004;
    localparam logic [31:0] OUT_ADDR_RST  = 32'h9000_0100;
    localparam logic [31:0] OUT_ADDR_STEP = 32'h0100_0000;
    localparam logic [31:0] CFG_ADDR_RST  = 32'h9000_0000;
    localparam logic [15:0] CFG_SIZE_RST  = 16'h0014;

    function automatic logic [31:0] apply_wstrb(logic [31:0] old_val,
                                                logic [31:0] wdata,
                                                logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/strela_ctrl_csr_if.sv
// Register-bus request/response bundle for the STRELA control CSR block.
interface strela_ctrl_csr_if;
    import strela_csr_pkg::*;

    reg_req_t req;
    reg_rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);
endinterface

// File: rtl/strela_ctrl_csr_seq.sv
// Configuration/execution sequencer: command FSM, one-cycle pulses, sticky
// done/error flags and the saturating execution cycle counter.
module strela_csr_seq
    import strela_csr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ctrl_we_i,
    input  logic [3:0]  ctrl_i,
    input  logic        done_cfg_i,
    input  logic        done_exec_i,
    output logic        load_cfg_o,
    output logic        start_exec_o,
    output logic        reset_sm_o,
    output logic [4:0]  status_o,
    output logic [31:0] cycles_o
);

    ctrl_state_e state_q;
    logic        done_exec_q, done_cfg_q, cmd_err_q;
    logic [31:0] cycles_q;

    // Later assignments override earlier ones: flag sets beat clear, and a
    // reset_sm command beats any state change or counter update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            load_cfg_o   <= 1'b0;
            start_exec_o <= 1'b0;
            reset_sm_o   <= 1'b0;
            done_exec_q  <= 1'b0;
            done_cfg_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            cycles_q     <= '0;
        end else begin
            load_cfg_o   <= 1'b0;
            start_exec_o <= 1'b0;
            reset_sm_o   <= 1'b0;

            if (ctrl_we_i && ctrl_i[CTRL_CLEAR]) begin
                done_exec_q <= 1'b0;
                done_cfg_q  <= 1'b0;
                cmd_err_q   <= 1'b0;
            end

            case (state_q)
                CFG: begin
                    if (done_cfg_i) begin
                        done_cfg_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                EXEC: begin
                    if (done_exec_i) begin
                        done_exec_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (cycles_q != '1) begin
                        cycles_q <= cycles_q + 32'd1;
                    end
                end
                default: ;
            endcase

            if (ctrl_we_i) begin
                if (ctrl_i[CTRL_RESET_SM]) begin
                    reset_sm_o <= 1'b1;
                    state_q    <= IDLE;
                    cycles_q   <= cycles_q;
                end else if (ctrl_i[CTRL_LOAD] || ctrl_i[CTRL_START]) begin
                    if (state_q != IDLE) begin
                        cmd_err_q <= 1'b1;
                    end else if (ctrl_i[CTRL_LOAD]) begin
                        load_cfg_o <= 1'b1;
                        state_q    <= CFG;
                        if (ctrl_i[CTRL_START]) cmd_err_q <= 1'b1;
                    end else begin
                        start_exec_o <= 1'b1;
                        cycles_q     <= '0;
                        state_q      <= EXEC;
                    end
                end
            end
        end
    end

    assign status_o = {cmd_err_q, (state_q == CFG), (state_q == EXEC),
                       done_cfg_q, done_exec_q};
    assign cycles_o = cycles_q;

endmodule

// File: rtl/strela_ctrl_csr.sv
// STRELA CGRA control/status register file: address decode and descriptor
// storage. Optional interrupt output enabled by defining STRELA_CSR_IRQ_EN.
module strela_ctrl_csr
    import strela_csr_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    strela_ctrl_csr_if.slave        reg_bus,
    output logic [N_IN-1:0][31:0]   in_addr_o,
    output logic [N_IN-1:0][15:0]   in_size_o,
    output logic [N_IN-1:0][15:0]   in_stride_o,
    output logic [N_OUT-1:0][31:0]  out_addr_o,
    output logic [N_OUT-1:0][15:0]  out_size_o,
    output logic [31:0]             cfg_addr_o,
    output logic [15:0]             cfg_size_o,
    output logic                    load_cfg_o,
    output logic                    start_exec_o,
    output logic                    reset_sm_o,
    input  logic                    done_cfg_i,
    input  logic                    done_exec_i,
    output logic                    irq_o
);

    localparam int unsigned CH_END = CH_BASE + CH_STRIDE * (N_IN + N_OUT);

    logic [31:0] a32, ch_idx, rdata;
    logic        ch_hit, ch_hi, err, wr_en, ctrl_we;
    logic [4:0]  status;
    logic [31:0] cycles;
    logic        unused_addr;

    assign a32         = 32'(reg_bus.req.addr[ADDR_W-1:0]);
    assign unused_addr = ^reg_bus.req.addr[31:ADDR_W];
    assign ch_hit      = (a32 >= CH_BASE) && (a32 < CH_END) && (a32[1:0] == 2'b00);
    assign ch_idx      = (a32 - CH_BASE) >> 3;
    assign ch_hi       = a32[2];

`ifdef STRELA_CSR_IRQ_EN
    logic [4:0] irq_en_q;
`endif

    always_comb begin
        rdata = '0;
        err   = 1'b0;
        if (a32[1:0] != 2'b00) begin
            err = 1'b1;
        end else if (a32 == CSR_CTRL) begin
            rdata = '0;
        end else if (a32 == CSR_STATUS) begin
            rdata = {27'd0, status};
            err   = reg_bus.req.write;
        end else if (a32 == CSR_CYCLES) begin
            rdata = cycles;
            err   = reg_bus.req.write;
        end else if (a32 == CSR_IRQ_EN) begin
`ifdef STRELA_CSR_IRQ_EN
            rdata = {27'd0, irq_en_q};
`endif
        end else if (a32 == CSR_CFG_ADDR) begin
            rdata = cfg_addr_o;
        end else if (a32 == CSR_CFG_SIZE) begin
            rdata = {16'd0, cfg_size_o};
        end else if (ch_hit) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (ch_idx == i) rdata = ch_hi ? {in_stride_o[i], in_size_o[i]} : in_addr_o[i];
            end
            for (int unsigned j = 0; j < N_OUT; j++) begin
                if (ch_idx == N_IN + j) rdata = ch_hi ? {16'd0, out_size_o[j]} : out_addr_o[j];
            end
        end else begin
            err = 1'b1;
        end
        if (err) rdata = '0;
    end

    assign reg_bus.rsp = '{rdata: rdata, error: err, ready: 1'b1};
    assign wr_en       = reg_bus.req.valid && reg_bus.req.write && !err;
    assign ctrl_we     = wr_en && (a32 == CSR_CTRL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                in_addr_o[i]   <= IN_ADDR_RST + 32'(i) * IN_ADDR_STEP;
                in_size_o[i]   <= '0;
                in_stride_o[i] <= IN_STRIDE_RST;
            end
            for (int unsigned j = 0; j < N_OUT; j++) begin
                out_addr_o[j] <= OUT_ADDR_RST + 32'(j) * OUT_ADDR_STEP;
                out_size_o[j] <= '0;
            end
            cfg_addr_o <= CFG_ADDR_RST;
            cfg_size_o <= CFG_SIZE_RST;
        end else if (wr_en) begin
            if (a32 == CSR_CFG_ADDR)
                cfg_addr_o <= apply_wstrb(cfg_addr_o, reg_bus.req.wdata, reg_bus.req.wstrb);
            if (a32 == CSR_CFG_SIZE)
                cfg_size_o <= 16'(apply_wstrb({16'd0, cfg_size_o}, reg_bus.req.wdata, reg_bus.req.wstrb));
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (ch_hit && ch_idx == i) begin
                    if (ch_hi)
                        {in_stride_o[i], in_size_o[i]} <= apply_wstrb({in_stride_o[i], in_size_o[i]},
                                                                      reg_bus.req.wdata, reg_bus.req.wstrb);
                    else
                        in_addr_o[i] <= apply_wstrb(in_addr_o[i], reg_bus.req.wdata, reg_bus.req.wstrb);
                end
            end
            for (int unsigned j = 0; j < N_OUT; j++) begin
                if (ch_hit && ch_idx == N_IN + j) begin
                    if (ch_hi)
                        out_size_o[j] <= 16'(apply_wstrb({16'd0, out_size_o[j]},
                                                         reg_bus.req.wdata, reg_bus.req.wstrb));
                    else
                        out_addr_o[j] <= apply_wstrb(out_addr_o[j], reg_bus.req.wdata, reg_bus.req.wstrb);
                end
            end
        end
    end

    strela_csr_seq u_seq (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ctrl_we_i    (ctrl_we),
        .ctrl_i       (reg_bus.req.wdata[3:0] & {4{reg_bus.req.wstrb[0]}}),
        .done_cfg_i   (done_cfg_i),
        .done_exec_i  (done_exec_i),
        .load_cfg_o   (load_cfg_o),
        .start_exec_o (start_exec_o),
        .reset_sm_o   (reset_sm_o),
        .status_o     (status),
        .cycles_o     (cycles)
    );

`ifdef STRELA_CSR_IRQ_EN
    // Only the done and cmd_err bits can raise an interrupt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= '0;
            irq_o    <= 1'b0;
        end else begin
            if (wr_en && a32 == CSR_IRQ_EN)
                irq_en_q <= 5'(apply_wstrb({27'd0, irq_en_q}, reg_bus.req.wdata,
                                           reg_bus.req.wstrb)) & 5'b10011;
            irq_o <= (|(status[1:0] & irq_en_q[1:0])) | (status[4] & irq_en_q[4]);
        end
    end
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_strela_ctrl_csr.sv
// Directed self-checking bench for strela_ctrl_csr (default or IRQ build).
module tb_strela_ctrl_csr;
    import strela_csr_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic done_cfg = 1'b0, done_exec = 1'b0;
    logic [3:0][31:0] in_addr, out_addr;
    logic [3:0][15:0] in_size, in_stride, out_size;
    logic [31:0] cfg_addr;
    logic [15:0] cfg_size;
    logic load_cfg, start_exec, reset_sm, irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rd;
    logic        e;

    strela_ctrl_csr_if bus ();

    strela_ctrl_csr #(.N_IN(4), .N_OUT(4), .ADDR_W(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .reg_bus      (bus.slave),
        .in_addr_o    (in_addr),
        .in_size_o    (in_size),
        .in_stride_o  (in_stride),
        .out_addr_o   (out_addr),
        .out_size_o   (out_size),
        .cfg_addr_o   (cfg_addr),
        .cfg_size_o   (cfg_size),
        .load_cfg_o   (load_cfg),
        .start_exec_o (start_exec),
        .reset_sm_o   (reset_sm),
        .done_cfg_i   (done_cfg),
        .done_exec_i  (done_exec),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic err);
        @(negedge clk);
        bus.req = '{addr: addr, write: 1'b1, wdata: data, wstrb: strb, valid: 1'b1};
        @(posedge clk);
        #1;
        err = bus.rsp.error;
        bus.req.valid = 1'b0;
        bus.req.write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        @(negedge clk);
        bus.req = '{addr: addr, write: 1'b0, wdata: 32'd0, wstrb: 4'd0, valid: 1'b1};
        #1;
        data = bus.rsp.rdata;
        err  = bus.rsp.error;
        bus.req.valid = 1'b0;
    endtask

    task automatic pulse_done(input bit exec);
        @(negedge clk);
        if (exec) done_exec = 1'b1; else done_cfg = 1'b1;
        @(posedge clk);
        #1;
        done_exec = 1'b0;
        done_cfg  = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset values
        bus_read(32'h20, rd, e); check("rst_in_addr0", rd, 32'h8000_0000);
        bus_read(32'h24, rd, e); check("rst_in_sz0", rd, 32'h0004_0000);
        bus_read(32'h04, rd, e); check("rst_status", rd, 32'h0);
        bus_read(32'h14, rd, e); check("rst_cfg_size", rd, 32'h14);
        bus_read(32'h28, rd, e); check("rst_in_addr1", rd, 32'h8100_0004);
        bus_read(32'h48, rd, e); check("rst_out_addr1", rd, 32'h9100_0100);
        check("rst_cfg_addr_port", cfg_addr, 32'h9000_0000);
        check("rst_pulses", {29'd0, load_cfg, start_exec, reset_sm}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);

        // Configuration load
        bus_write(32'h00, 32'h2, 4'hF, e);
        check("load_pulse_hi", {31'd0, load_cfg}, 32'h1);
        @(posedge clk); #1;
        check("load_pulse_lo", {31'd0, load_cfg}, 32'h0);
        bus_read(32'h04, rd, e); check("status_cfg_busy", rd, 32'h8);
        pulse_done(1'b1);
        bus_read(32'h04, rd, e); check("done_exec_in_cfg_ignored", rd, 32'h8);
        pulse_done(1'b0);
        bus_read(32'h04, rd, e); check("status_cfg_done", rd, 32'h2);
        bus_write(32'h00, 32'h8, 4'hF, e);
        bus_read(32'h04, rd, e); check("status_clr1", rd, 32'h0);

        // Execution with cycle count
        bus_write(32'h00, 32'h1, 4'hF, e);
        check("start_pulse", {31'd0, start_exec}, 32'h1);
        repeat (50) @(posedge clk);
        #1 done_exec = 1'b1;
        @(posedge clk);
        #1 done_exec = 1'b0;
        bus_read(32'h04, rd, e); check("status_exec_done", rd, 32'h1);
        bus_read(32'h08, rd, e); check("cycles_50", rd, 32'd50);
        bus_write(32'h00, 32'h8, 4'hF, e);
        bus_read(32'h04, rd, e); check("status_clr2", rd, 32'h0);
        pulse_done(1'b1);
        bus_read(32'h04, rd, e); check("done_exec_idle_ignored", rd, 32'h0);

        // Illegal command during EXEC, then datapath reset
        bus_write(32'h00, 32'h1, 4'hF, e);
        bus_write(32'h00, 32'h2, 4'hF, e);
        check("no_load_in_exec", {31'd0, load_cfg}, 32'h0);
        bus_read(32'h04, rd, e); check("status_cmd_err", rd, 32'h14);
        bus_write(32'h00, 32'h4, 4'hF, e);
        check("reset_sm_pulse", {31'd0, reset_sm}, 32'h1);
        bus_read(32'h04, rd, e); check("status_after_rsm", rd, 32'h10);
        bus_read(32'h08, rd, e); check("cycles_hold", rd, 32'd2);
        bus_write(32'h00, 32'h8, 4'hF, e);

        // load+start together: load wins, cmd_err set
        bus_write(32'h00, 32'h3, 4'hF, e);
        check("both_pulses", {30'd0, load_cfg, start_exec}, 32'h2);
        bus_read(32'h04, rd, e); check("status_both", rd, 32'h18);
        pulse_done(1'b0);
        bus_write(32'h00, 32'h8, 4'hF, e);
        bus_read(32'h04, rd, e); check("status_clr3", rd, 32'h0);

        // Byte strobes and error responses
        bus_write(32'h24, 32'hFFFF_FFFF, 4'b0011, e);
        check("wr_strb_err", {31'd0, e}, 32'h0);
        bus_read(32'h24, rd, e); check("strb_read", rd, 32'h0004_FFFF);
        check("in_size0_port", {16'd0, in_size[0]}, 32'hFFFF);
        bus_write(32'h10, 32'h12AB_CDEF, 4'b1000, e);
        check("cfg_addr_strb", cfg_addr, 32'h1200_0000);
        bus_write(32'h4C, 32'h1234_5678, 4'hF, e);
        bus_read(32'h4C, rd, e); check("out_size1_read", rd, 32'h0000_5678);
        check("out_size1_port", {16'd0, out_size[1]}, 32'h5678);
        bus_write(32'h04, 32'hFF, 4'hF, e);
        check("wr_status_err", {31'd0, e}, 32'h1);
        bus_read(32'h04, rd, e); check("status_unchanged", rd, 32'h0);
        bus_write(32'hFC, 32'h1, 4'hF, e);
        check("wr_unmapped_err", {31'd0, e}, 32'h1);
        bus_read(32'hFC, rd, e);
        check("rd_unmapped", {rd[30:0], e}, 32'h1);
        bus_read(32'h00, rd, e);
        check("rd_ctrl", {rd[30:0], e}, 32'h0);

`ifdef STRELA_CSR_IRQ_EN
        bus_write(32'h0C, 32'h1, 4'hF, e);
        check("irq_en_wr_err", {31'd0, e}, 32'h0);
        bus_read(32'h0C, rd, e); check("irq_en_read", rd, 32'h1);
        bus_write(32'h00, 32'h1, 4'hF, e);
        pulse_done(1'b1);
        check("irq_not_yet", {31'd0, irq}, 32'h0);
        @(posedge clk); #1;
        check("irq_rise", {31'd0, irq}, 32'h1);
        bus_write(32'h00, 32'h8, 4'hF, e);
        check("irq_still", {31'd0, irq}, 32'h1);
        @(posedge clk); #1;
        check("irq_fall", {31'd0, irq}, 32'h0);
`else
        bus_write(32'h0C, 32'h13, 4'hF, e);
        check("irq_en_wr_err", {31'd0, e}, 32'h0);
        bus_read(32'h0C, rd, e); check("irq_en_read", rd, 32'h0);
        bus_write(32'h00, 32'h1, 4'hF, e);
        pulse_done(1'b1);
        @(posedge clk); #1;
        check("irq_tied", {31'd0, irq}, 32'h0);
        bus_write(32'h00, 32'h8, 4'hF, e);
`endif

        // Asynchronous reset mid-execution
        bus_write(32'h00, 32'h1, 4'hF, e);
        #3 rst_n = 1'b0;
        #1;
        check("arst_size0", {16'd0, in_size[0]}, 32'h0);
        check("arst_cfg_addr", cfg_addr, 32'h9000_0000);
        bus_read(32'h04, rd, e); check("arst_status", rd, 32'h0);
        bus_read(32'h08, rd, e); check("arst_cycles", rd, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
